multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle opcode decoder. Sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB states over a shared instruction/data memory with a ready handshake, and drives datapath enables and mux selects per state. Supports R, I-ALU, LW, SW, BEQ, JAL, JALR, LUI and AUIPC. Adds illegal-opcode and memory-timeout traps.

---
 rtl/multicycle_control_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RV32I control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory with a ready
// handshake. Traps on illegal opcodes and on memory waits that run too long.
// Optional build macro MCU_PERF_CNT_EN adds cycle_cnt_o / instret_o counters.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_wr_o,
  output logic        ir_wr_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        i_or_d_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  pc_src_o,
  output logic        reg_wr_o,
  output logic [1:0]  wb_sel_o,
  output logic [2:0]  state_o,
  output logic        illegal_o,
  output logic        timeout_o
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_o
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_IALU  = 5'b00100;
  localparam logic [4:0] OP_LW    = 5'b00000;
  localparam logic [4:0] OP_SW    = 5'b01000;
  localparam logic [4:0] OP_BEQ   = 5'b11000;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;

  // Last wait count tolerated before a stalled access traps
  localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           next_state;
  logic [TMO_W-1:0] wait_cnt;
  logic             set_illegal;
  logic             set_timeout;
  logic             legal_op;
  logic             mem_phase;

  assign legal_op = (opcode_i == OP_R)    || (opcode_i == OP_IALU) ||
                    (opcode_i == OP_LW)   || (opcode_i == OP_SW)   ||
                    (opcode_i == OP_BEQ)  || (opcode_i == OP_JAL)  ||
                    (opcode_i == OP_JALR) || (opcode_i == OP_LUI)  ||
                    (opcode_i == OP_AUIPC);
  assign mem_phase = (state == S_FETCH) || (state == S_MEM);
  assign state_o   = state;

  // Datapath controls and next state from current state plus same-cycle inputs;
  // everything is held at zero while reset is asserted so an access aborts at once
  always_comb begin
    next_state  = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    pc_wr_o     = 1'b0;
    ir_wr_o     = 1'b0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    i_or_d_o    = 1'b0;
    alu_src_a_o = 2'd0;
    alu_src_b_o = 2'd0;
    alu_op_o    = 2'b00;
    pc_src_o    = 2'd0;
    reg_wr_o    = 1'b0;
    wb_sel_o    = 2'd0;
    if (rst_n_i) begin
      case (state)
        S_FETCH: begin
          mem_rd_o    = 1'b1;
          alu_src_b_o = 2'd2;
          if (mem_ready_i) begin
            ir_wr_o    = 1'b1;
            pc_wr_o    = 1'b1;
            next_state = S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            next_state  = S_TRAP;
            set_timeout = 1'b1;
          end
        end
        S_DECODE: begin
          alu_src_b_o = 2'd1;
          if (legal_op) begin
            next_state = S_EXEC;
          end else begin
            next_state  = S_TRAP;
            set_illegal = 1'b1;
          end
        end
        S_EXEC: begin
          case (opcode_i)
            OP_R: begin
              alu_src_a_o = 2'd1;
              alu_op_o    = 2'b10;
              next_state  = S_WB;
            end
            OP_IALU: begin
              alu_src_a_o = 2'd1;
              alu_src_b_o = 2'd1;
              alu_op_o    = 2'b10;
              next_state  = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_src_a_o = 2'd1;
              alu_src_b_o = 2'd1;
              next_state  = S_MEM;
            end
            OP_BEQ: begin
              alu_src_a_o = 2'd1;
              alu_op_o    = 2'b01;
              pc_src_o    = 2'd1;
              pc_wr_o     = zero_i;
              next_state  = S_FETCH;
            end
            OP_JAL: begin
              pc_src_o   = 2'd1;
              pc_wr_o    = 1'b1;
              next_state = S_WB;
            end
            OP_JALR: begin
              alu_src_a_o = 2'd1;
              alu_src_b_o = 2'd1;
              pc_wr_o     = 1'b1;
              next_state  = S_WB;
            end
            OP_LUI: begin
              alu_src_a_o = 2'd2;
              alu_src_b_o = 2'd1;
              next_state  = S_WB;
            end
            OP_AUIPC: begin
              next_state = S_WB;
            end
            default: begin
              next_state  = S_TRAP;
              set_illegal = 1'b1;
            end
          endcase
        end
        S_MEM: begin
          i_or_d_o = 1'b1;
          mem_rd_o = (opcode_i == OP_LW);
          mem_wr_o = (opcode_i == OP_SW);
          if (mem_ready_i) begin
            next_state = (opcode_i == OP_LW) ? S_WB : S_FETCH;
          end else if (wait_cnt == WAIT_LAST) begin
            next_state  = S_TRAP;
            set_timeout = 1'b1;
          end
        end
        S_WB: begin
          reg_wr_o = 1'b1;
          if (opcode_i == OP_LW) begin
            wb_sel_o = 2'd1;
          end else if ((opcode_i == OP_JAL) || (opcode_i == OP_JALR)) begin
            wb_sel_o = 2'd2;
          end
          next_state = S_FETCH;
        end
        default: begin
          next_state = S_TRAP;
        end
      endcase
    end
  end

  // State register, memory wait counter and sticky trap flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      illegal_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state <= next_state;
      if (mem_phase && !mem_ready_i && (next_state == state)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (set_illegal) begin
        illegal_o <= 1'b1;
      end
      if (set_timeout) begin
        timeout_o <= 1'b1;
      end
    end
  end

`ifdef MCU_PERF_CNT_EN
  // Cycles outside TRAP and instructions retired on the return to FETCH
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycle_cnt_o <= '0;
      instret_o   <= '0;
    end else begin
      if (state != S_TRAP) begin
        cycle_cnt_o <= cycle_cnt_o + 32'd1;
      end
      if ((next_state == S_FETCH) &&
          ((state == S_EXEC) || (state == S_MEM) || (state == S_WB))) begin
        instret_o <= instret_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: self-checking bench for multicycle_control_unit.
// Directed vector table, hand-written corner sequences and a randomized
// instruction stream checked against a per-instruction phase model.
// Counter checks are compiled in when MCU_PERF_CNT_EN is defined.
module tb_multicycle_control_unit;

  localparam int MEM_TIMEOUT = 4;
  localparam int TMO_W       = 3;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_IALU  = 5'b00100;
  localparam logic [4:0] OP_LW    = 5'b00000;
  localparam logic [4:0] OP_SW    = 5'b01000;
  localparam logic [4:0] OP_BEQ   = 5'b11000;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_BAD   = 5'b11111;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [4:0]  opcode_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        pc_wr_o;
  logic        ir_wr_o;
  logic        mem_rd_o;
  logic        mem_wr_o;
  logic        i_or_d_o;
  logic [1:0]  alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [1:0]  alu_op_o;
  logic [1:0]  pc_src_o;
  logic        reg_wr_o;
  logic [1:0]  wb_sel_o;
  logic [2:0]  state_o;
  logic        illegal_o;
  logic        timeout_o;
`ifdef MCU_PERF_CNT_EN
  logic [31:0] cycle_cnt_o;
  logic [31:0] instret_o;
`endif

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMO_W(TMO_W)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n_i),
    .opcode_i(opcode_i),
    .zero_i(zero_i),
    .mem_ready_i(mem_ready_i),
    .pc_wr_o(pc_wr_o),
    .ir_wr_o(ir_wr_o),
    .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o),
    .i_or_d_o(i_or_d_o),
    .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o),
    .pc_src_o(pc_src_o),
    .reg_wr_o(reg_wr_o),
    .wb_sel_o(wb_sel_o),
    .state_o(state_o),
    .illegal_o(illegal_o),
    .timeout_o(timeout_o)
`ifdef MCU_PERF_CNT_EN
    ,
    .cycle_cnt_o(cycle_cnt_o),
    .instret_o(instret_o)
`endif
  );

  // Full control word and the reduced word used by the random model
  logic [18:0] act;
  logic [9:0]  ract;
  assign act  = {state_o, pc_wr_o, ir_wr_o, mem_rd_o, mem_wr_o, i_or_d_o,
                 alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o, reg_wr_o, wb_sel_o};
  assign ract = {state_o, pc_wr_o, ir_wr_o, mem_rd_o, mem_wr_o, reg_wr_o, wb_sel_o};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  opc;
    logic        zero;
    logic        rdy;
    logic [18:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0] opc;
    logic       zero;
    logic       rdy;
    logic [9:0] exp;
  } rnd_t;

  vec_t vecs[$];
  rnd_t model_q[$];

  // Build an expected full control word from spec field values
  function automatic logic [18:0] ex(input int st, input int pcw, input int irw,
                                     input int rd, input int wr, input int iod,
                                     input int a, input int b, input int op,
                                     input int ps, input int rw, input int wbs);
    return {st[2:0], pcw[0], irw[0], rd[0], wr[0], iod[0],
            a[1:0], b[1:0], op[1:0], ps[1:0], rw[0], wbs[1:0]};
  endfunction

  task automatic addVec(input logic [4:0] opc, input logic z, input logic r,
                        input logic [18:0] e);
    vec_t v;
    v.opc = opc;
    v.zero = z;
    v.rdy = r;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic modelPush(input logic [4:0] opc, input logic z, input logic r,
                           input int st, input int pcw, input int irw, input int rd,
                           input int wr, input int rw, input int wbs);
    rnd_t m;
    m.opc = opc;
    m.zero = z;
    m.rdy = r;
    m.exp = {st[2:0], pcw[0], irw[0], rd[0], wr[0], rw[0], wbs[1:0]};
    model_q.push_back(m);
  endtask

  // Expand one instruction into its expected cycle-by-cycle phases
  task automatic modelInstr(input logic [4:0] opc, input logic z, input int fw,
                            input int mw);
    int pcw_ex;
    int wbs;
    bit is_lw;
    bit is_sw;
    is_lw = (opc == OP_LW);
    is_sw = (opc == OP_SW);
    for (int i = 0; i < fw; i++) modelPush(opc, z, 1'b0, 0, 0, 0, 1, 0, 0, 0);
    modelPush(opc, z, 1'b1, 0, 1, 1, 1, 0, 0, 0);
    modelPush(opc, z, 1'($urandom_range(0, 1)), 1, 0, 0, 0, 0, 0, 0);
    if (opc == OP_BEQ) pcw_ex = int'(z);
    else if ((opc == OP_JAL) || (opc == OP_JALR)) pcw_ex = 1;
    else pcw_ex = 0;
    modelPush(opc, z, 1'($urandom_range(0, 1)), 2, pcw_ex, 0, 0, 0, 0, 0);
    if (is_lw || is_sw) begin
      for (int i = 0; i < mw; i++)
        modelPush(opc, z, 1'b0, 3, 0, 0, int'(is_lw), int'(is_sw), 0, 0);
      modelPush(opc, z, 1'b1, 3, 0, 0, int'(is_lw), int'(is_sw), 0, 0);
    end
    if (!is_sw && (opc != OP_BEQ)) begin
      if (is_lw) wbs = 1;
      else if ((opc == OP_JAL) || (opc == OP_JALR)) wbs = 2;
      else wbs = 0;
      modelPush(opc, z, 1'($urandom_range(0, 1)), 4, 0, 0, 0, 0, 1, wbs);
    end
  endtask

  // Drive inputs for this cycle and let combinational outputs settle
  task automatic applyStimulus(input logic [4:0] opc, input logic z, input logic r);
    opcode_i    = opc;
    zero_i      = z;
    mem_ready_i = r;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  // Hold reset two cycles, release on a falling edge before any rising edge
  task automatic doReset();
    rst_n_i     = 1'b0;
    opcode_i    = 5'd0;
    zero_i      = 1'b0;
    mem_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n_i = 1'b1;
  endtask

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    logic [18:0] f0, f1, dec, wb0, wb1, wb2, ex_ldst, mem_lw, mem_sw, trap_q;
    logic [4:0]  ops[9];
    int          n_instr;
    int          n_cycles;

    f0      = ex(0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0);
    f1      = ex(0, 1, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0);
    dec     = ex(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    wb0     = ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    wb1     = ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    wb2     = ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    ex_ldst = ex(2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    mem_lw  = ex(3, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    mem_sw  = ex(3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    trap_q  = ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    addVec(OP_R, 1'b0, 1'b1, f1);
    addVec(OP_R, 1'b0, 1'b1, dec);
    addVec(OP_R, 1'b0, 1'b1, ex(2, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0));
    addVec(OP_R, 1'b0, 1'b1, wb0);
    addVec(OP_IALU, 1'b0, 1'b1, f1);
    addVec(OP_IALU, 1'b0, 1'b1, dec);
    addVec(OP_IALU, 1'b0, 1'b1, ex(2, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0));
    addVec(OP_IALU, 1'b0, 1'b1, wb0);
    addVec(OP_LW, 1'b0, 1'b1, f1);
    addVec(OP_LW, 1'b0, 1'b1, dec);
    addVec(OP_LW, 1'b0, 1'b1, ex_ldst);
    addVec(OP_LW, 1'b0, 1'b0, mem_lw);
    addVec(OP_LW, 1'b0, 1'b0, mem_lw);
    addVec(OP_LW, 1'b0, 1'b0, mem_lw);
    addVec(OP_LW, 1'b0, 1'b1, mem_lw);
    addVec(OP_LW, 1'b0, 1'b1, wb1);
    addVec(OP_SW, 1'b0, 1'b1, f1);
    addVec(OP_SW, 1'b0, 1'b1, dec);
    addVec(OP_SW, 1'b0, 1'b1, ex_ldst);
    addVec(OP_SW, 1'b0, 1'b1, mem_sw);
    addVec(OP_BEQ, 1'b1, 1'b1, f1);
    addVec(OP_BEQ, 1'b1, 1'b1, dec);
    addVec(OP_BEQ, 1'b1, 1'b1, ex(2, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    addVec(OP_BEQ, 1'b0, 1'b1, f1);
    addVec(OP_BEQ, 1'b0, 1'b1, dec);
    addVec(OP_BEQ, 1'b0, 1'b1, ex(2, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
    addVec(OP_JAL, 1'b0, 1'b1, f1);
    addVec(OP_JAL, 1'b0, 1'b1, dec);
    addVec(OP_JAL, 1'b0, 1'b1, ex(2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    addVec(OP_JAL, 1'b0, 1'b1, wb2);
    addVec(OP_JALR, 1'b0, 1'b1, f1);
    addVec(OP_JALR, 1'b0, 1'b1, dec);
    addVec(OP_JALR, 1'b0, 1'b1, ex(2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    addVec(OP_JALR, 1'b0, 1'b1, wb2);
    addVec(OP_LUI, 1'b0, 1'b1, f1);
    addVec(OP_LUI, 1'b0, 1'b1, dec);
    addVec(OP_LUI, 1'b0, 1'b1, ex(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
    addVec(OP_LUI, 1'b0, 1'b1, wb0);
    addVec(OP_AUIPC, 1'b0, 1'b0, f0);
    addVec(OP_AUIPC, 1'b0, 1'b1, f1);
    addVec(OP_AUIPC, 1'b0, 1'b1, dec);
    addVec(OP_AUIPC, 1'b0, 1'b1, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(OP_AUIPC, 1'b0, 1'b1, wb0);
    addVec(OP_R, 1'b0, 1'b1, f1);

    // Reset state, then a reset pulse in the middle of a stalled fetch
    doReset();
    applyStimulus(OP_R, 1'b0, 1'b0);
    checkOutput("reset_fetch_word", 32'(act), 32'(f0));
    checkOutput("reset_flags", {30'd0, illegal_o, timeout_o}, 32'd0);
    nextCycle();
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("midfetch_rst_mem_rd", 32'(mem_rd_o), 32'd0);
    checkOutput("midfetch_rst_state", 32'(state_o), 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;

    // Directed vector table, one entry per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].opc, vecs[i].zero, vecs[i].rdy);
      checkOutput($sformatf("table[%0d]", i), 32'(act), 32'(vecs[i].exp));
      nextCycle();
    end

    // Reset asserted while a store is waiting in MEM
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_SW, 1'b0, 1'b1);
      nextCycle();
    end
    applyStimulus(OP_SW, 1'b0, 1'b0);
    checkOutput("sw_mem_wr_before_rst", 32'(mem_wr_o), 32'd1);
    nextCycle();
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("midmem_rst_mem_wr", 32'(mem_wr_o), 32'd0);
    checkOutput("midmem_rst_state", 32'(state_o), 32'd0);

    // Illegal opcode trap and its release by reset
    doReset();
    applyStimulus(OP_BAD, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(OP_BAD, 1'b0, 1'b1);
    checkOutput("illegal_decode_state", 32'(state_o), 32'd1);
    nextCycle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(OP_BAD, 1'(i), 1'(i));
      checkOutput($sformatf("trap_quiet[%0d]", i), 32'(act), 32'(trap_q));
      checkOutput($sformatf("illegal_flag[%0d]", i), 32'(illegal_o), 32'd1);
      nextCycle();
    end
    rst_n_i = 1'b0;
    #1;
    checkOutput("illegal_cleared", 32'(illegal_o), 32'd0);

    // Fetch timeout: four unanswered cycles then TRAP
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_R, 1'b0, 1'b0);
      checkOutput($sformatf("tmo_wait_state[%0d]", i), 32'(state_o), 32'd0);
      nextCycle();
    end
    applyStimulus(OP_R, 1'b0, 1'b0);
    checkOutput("tmo_trap_word", 32'(act), 32'(trap_q));
    checkOutput("tmo_flag", 32'(timeout_o), 32'd1);
    checkOutput("tmo_no_illegal", 32'(illegal_o), 32'd0);

    // Ready on the last allowed wait cycle wins over the trap
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_R, 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(OP_R, 1'b0, 1'b1);
    checkOutput("tmo_edge_ir_wr", 32'(ir_wr_o), 32'd1);
    nextCycle();
    applyStimulus(OP_R, 1'b0, 1'b0);
    checkOutput("tmo_edge_decode", 32'(state_o), 32'd1);
    checkOutput("tmo_edge_no_flag", 32'(timeout_o), 32'd0);

`ifdef MCU_PERF_CNT_EN
    // SW then JAL with no wait states: 8 cycles, 2 retired
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_SW, 1'b0, 1'b1);
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_JAL, 1'b0, 1'b1);
      nextCycle();
    end
    applyStimulus(OP_R, 1'b0, 1'b0);
    checkOutput("perf_cycles", cycle_cnt_o, 32'd8);
    checkOutput("perf_instret", instret_o, 32'd2);
`endif

    // Randomized instruction stream against the phase model
    ops = '{OP_R, OP_IALU, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    n_instr = 40;
    for (int k = 0; k < n_instr; k++) begin
      modelInstr(ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    n_cycles = model_q.size();
    doReset();
    for (int i = 0; i < n_cycles; i++) begin
      applyStimulus(model_q[i].opc, model_q[i].zero, model_q[i].rdy);
      checkOutput($sformatf("rnd[%0d]", i), 32'(ract), 32'(model_q[i].exp));
      nextCycle();
    end
    applyStimulus(OP_R, 1'b0, 1'b0);
    checkOutput("rnd_end_state", 32'(state_o), 32'd0);
    checkOutput("rnd_end_flags", {30'd0, illegal_o, timeout_o}, 32'd0);
`ifdef MCU_PERF_CNT_EN
    checkOutput("rnd_cycles", cycle_cnt_o, 32'(n_cycles));
    checkOutput("rnd_instret", instret_o, 32'(n_instr));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
